// File: rtl/key_conditioner.sv
// key_conditioner: per-key two-flop synchroniser, counter debouncer and registered press/release pulses
module key_conditioner #(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 20
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_db_n,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   logic [NUM_KEYS-1:0]  s1, s2;
   logic [CNT_WIDTH-1:0] cnt [NUM_KEYS];
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1          <= '1;
         s2          <= '1;
         key_level   <= '0;
         key_press   <= '0;
         key_release <= '0;
         cnt         <= '{default: '0};
      end else begin
         s1 <= key_n;
         s2 <= s1;
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_press[i]   <= 1'b0;
            key_release[i] <= 1'b0;
            if (s2[i] != key_level[i]) cnt[i] <= '0;
            else if (cnt[i] != LAST) cnt[i] <= cnt[i] + 1'b1;
            else begin
               cnt[i]         <= '0;
               key_level[i]   <= ~s2[i];
               key_press[i]   <= ~s2[i];
               key_release[i] <= s2[i];
            end
         end
      end
   end
   assign key_db_n = ~key_level;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: randomized and directed checks against a history-based debounce model
module tb_key_conditioner;
   localparam int N = 3;
   localparam int D = 4;
   localparam int HMAX = 4096;
   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic [N-1:0] key_n = '1;
   logic [N-1:0] key_level, key_db_n, key_press, key_release;
   logic [N-1:0] level_1, db_n_1, press_1, release_1;
   int checks = 0;
   int errors = 0;
   int t = 0;
   logic [N-1:0] kn_h [HMAX];
   bit           rst_h [HMAX];
   logic [N-1:0] m_level [2];
   logic [N-1:0] m_press [2];
   logic [N-1:0] m_release [2];

   key_conditioner #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(20)) dut (
      .Clk(Clk), .Reset(Reset), .key_n(key_n), .key_level(key_level),
      .key_db_n(key_db_n), .key_press(key_press), .key_release(key_release));

   key_conditioner #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(4)) dut1 (
      .Clk(Clk), .Reset(Reset), .key_n(key_n), .key_level(level_1),
      .key_db_n(db_n_1), .key_press(press_1), .key_release(release_1));

   always #5 Clk = ~Clk;

   // raw level the debouncer sees at edge j: input from two edges back, forced released near reset
   function automatic bit seen(int j, int k);
      if (j < 2 || rst_h[j-1] || rst_h[j-2]) return 1'b1;
      return kn_h[j-2][k];
   endfunction

   task automatic step();
      @(posedge Clk);
      kn_h[t]  = key_n;
      rst_h[t] = Reset;
      for (int m = 0; m < 2; m++) begin
         int dd = (m == 0) ? D : 1;
         for (int k = 0; k < N; k++) begin
            bit acc = !Reset;
            for (int j = t - dd + 1; j <= t; j++)
               if (j < 0 || rst_h[j] || ((!seen(j, k)) == m_level[m][k])) acc = 1'b0;
            m_press[m][k]   = acc && !m_level[m][k];
            m_release[m][k] = acc && m_level[m][k];
            if (Reset) m_level[m][k] = 1'b0;
            else if (acc) m_level[m][k] = !m_level[m][k];
         end
      end
      t++;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      key_n = '1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({key_level, key_db_n, key_press, key_release} !== {3'b000, 3'b111, 3'b000, 3'b000}) begin
            errors++;
            $display("FAIL reset t=%0d got lvl=%b dbn=%b prs=%b rel=%b exp 000 111 000 000", t, key_level, key_db_n, key_press, key_release);
         end
      end
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({key_level, key_db_n, key_press, key_release} !== {m_level[0], ~m_level[0], m_press[0], m_release[0]}) begin
            errors++;
            $display("FAIL reset_idle t=%0d got %b exp %b", t, {key_level, key_db_n, key_press, key_release}, {m_level[0], ~m_level[0], m_press[0], m_release[0]});
         end
      end
   endtask

   task automatic test_press_release();
      key_n[0] = 1'b0;
      for (int i = 0; i < 28; i++) begin
         if (i == 20) key_n[0] = 1'b1;
         step();
         checks++;
         if ({key_press[0], key_release[0], key_level[0], key_db_n[0]} !== {i == 5, i == 25, i >= 5 && i < 25, !(i >= 5 && i < 25)}) begin
            errors++;
            $display("FAIL press_release edge=%0d got prs=%b rel=%b lvl=%b dbn=%b", i, key_press[0], key_release[0], key_level[0], key_db_n[0]);
         end
         checks++;
         if ({key_level, key_db_n, key_press, key_release} !== {m_level[0], ~m_level[0], m_press[0], m_release[0]}) begin
            errors++;
            $display("FAIL press_release_model t=%0d got %b exp %b", t, {key_level, key_db_n, key_press, key_release}, {m_level[0], ~m_level[0], m_press[0], m_release[0]});
         end
      end
   endtask

   task automatic test_min_debounce();
      for (int i = 0; i < 10; i++) begin
         key_n[0] = (i < 5) ? 1'b0 : 1'b1;
         step();
         checks++;
         if ({press_1[0], release_1[0]} !== {i == 2, i == 7}) begin
            errors++;
            $display("FAIL min_debounce edge=%0d got prs=%b rel=%b exp prs=%b rel=%b", i, press_1[0], release_1[0], i == 2, i == 7);
         end
         checks++;
         if ({level_1, db_n_1, press_1, release_1} !== {m_level[1], ~m_level[1], m_press[1], m_release[1]}) begin
            errors++;
            $display("FAIL min_debounce_model t=%0d got %b exp %b", t, {level_1, db_n_1, press_1, release_1}, {m_level[1], ~m_level[1], m_press[1], m_release[1]});
         end
      end
      repeat (6) step();
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 14; i++) begin
         key_n[1] = (i < 2 || i == 3 || i == 4) ? 1'b0 : 1'b1;
         step();
         checks++;
         if ({key_level[1], key_press[1], key_release[1]} !== 3'b000) begin
            errors++;
            $display("FAIL bounce edge=%0d got lvl=%b prs=%b rel=%b exp 000", i, key_level[1], key_press[1], key_release[1]);
         end
      end
   endtask

   task automatic test_simultaneous();
      key_n = 3'b001;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) key_n = 3'b111;
         step();
         checks++;
         if ({key_press, key_release} !== {(i == 5) ? 3'b110 : 3'b000, (i == 13) ? 3'b110 : 3'b000}) begin
            errors++;
            $display("FAIL simultaneous edge=%0d got prs=%b rel=%b", i, key_press, key_release);
         end
      end
   endtask

   task automatic test_reset_mid();
      key_n[2] = 1'b0;
      repeat (3) step();
      Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({key_level[2], key_db_n[2], key_press[2]} !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_hold edge=%0d got lvl=%b dbn=%b prs=%b exp 010", i, key_level[2], key_db_n[2], key_press[2]);
         end
      end
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (key_press[2] !== (i == D + 1)) begin
            errors++;
            $display("FAIL reset_mid_press edge=%0d got %b exp %b", i, key_press[2], i == D + 1);
         end
      end
      key_n = '1;
      repeat (8) step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 900; i++) begin
         for (int k = 0; k < N; k++)
            if ($urandom_range(5) == 0) key_n[k] = ~key_n[k];
         Reset = ($urandom_range(99) == 0);
         step();
         for (int m = 0; m < 2; m++) begin
            logic [4*N-1:0] got = (m == 0) ? {key_level, key_db_n, key_press, key_release}
                                           : {level_1, db_n_1, press_1, release_1};
            checks++;
            if (got !== {m_level[m], ~m_level[m], m_press[m], m_release[m]}) begin
               errors++;
               $display("FAIL random inst=%0d t=%0d got %b exp %b", m, t, got, {m_level[m], ~m_level[m], m_press[m], m_release[m]});
            end
         end
         checks++;
         if ((key_press & key_release) !== '0) begin
            errors++;
            $display("FAIL random_exclusive t=%0d got prs=%b rel=%b", t, key_press, key_release);
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_level[m] = '0;
         m_press[m] = '0;
         m_release[m] = '0;
      end
      test_reset();
      test_press_release();
      test_min_debounce();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
